// File: rtl/cmult_pkg.sv
// Shared constants and complex-word pack/unpack helpers for the pipelined complex multiplier.
package cmult_pkg;

  localparam int RND_TRUNC   = 32'sd0;
  localparam int RND_HALF_UP = 32'sd1;

  // Helpers work on a fixed container; callers pass their component width (<= MAX_W).
  localparam int MAX_W = 32'sd32;
  typedef logic [2*MAX_W-1:0] cword_t;
  typedef logic [MAX_W-1:0]   comp_t;

  localparam cword_t ONE_W = cword_t'(1'b1);

  function automatic cword_t cmask(input int unsigned w);
    return (ONE_W << w) - ONE_W;
  endfunction

  function automatic cword_t cpack(input comp_t re, input comp_t im, input int unsigned w);
    return ((cword_t'(re) & cmask(w)) << w) | (cword_t'(im) & cmask(w));
  endfunction

  function automatic comp_t cre(input cword_t x, input int unsigned w);
    return comp_t'((x >> w) & cmask(w));
  endfunction

  function automatic comp_t cim(input cword_t x, input int unsigned w);
    return comp_t'(x & cmask(w));
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Final round / shift / saturate of one full-precision sum down to a WIDTH-bit component.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int WIDTH = 32'sd16,
  parameter int FRAC  = WIDTH - 32'sd1,
  parameter int ROUND = RND_HALF_UP,
  parameter int SAT   = 32'sd1
) (
  input  logic signed [2*WIDTH+1:0] sum,
  output logic        [WIDTH-1:0]   res,
  output logic                      ovf
);

  // One guard bit above the sum so the rounding add can never wrap.
  localparam int EW = 2 * WIDTH + 3;
  localparam logic signed [EW-1:0] HI_V  = EW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] LO_V  = ~HI_V;
  localparam logic signed [EW-1:0] RND_V = (ROUND == RND_HALF_UP) ?
                                           EW'(64'sd1 <<< (FRAC - 1)) : {EW{1'b0}};

  logic signed [EW-1:0] sum_ext_s;
  logic signed [EW-1:0] shifted_s;

  always_comb begin
    sum_ext_s = EW'(sum);
    shifted_s = (sum_ext_s + RND_V) >>> FRAC;
    res       = shifted_s[WIDTH-1:0];
    ovf       = 1'b0;
    if (shifted_s > HI_V) begin
      ovf = 1'b1;
      res = (SAT != 0) ? HI_V[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    end else if (shifted_s < LO_V) begin
      ovf = 1'b1;
      res = (SAT != 0) ? LO_V[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    end else begin
      ovf = 1'b0;
      res = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage complex multiplier a*b (or a*conj(b)) with valid/ready flow control,
// full-precision products and a single final round/saturate step.
module complex_mult_pipe
  import cmult_pkg::*;
#(
  parameter int WIDTH = 32'sd16,
  parameter int FRAC  = WIDTH - 32'sd1,
  parameter int ROUND = RND_HALF_UP,
  parameter int SAT   = 32'sd1,
  parameter int TAG_W = 32'sd5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0]   b,
  input  logic                 conj_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_ovf,
  output logic                 ovf_sticky,
  input  logic                 clr_ovf
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int SW = 2 * WIDTH + 2;

  logic en_s;
  logic v1_r, v2_r, v3_r;

  logic signed [WIDTH-1:0] a_re_s, a_im_s, b_re_s, b_im_s;
  logic signed [WIDTH:0]   b_im_ext_s, bi_eff_s;

  logic signed [WIDTH-1:0] ar1_r, ai1_r, br1_r;
  logic signed [WIDTH:0]   bi1_r;
  logic [TAG_W-1:0]        tag1_r, tag2_r;

  logic signed [PW-1:0]    p_rr_r, p_ii_r, p_ri_r, p_ir_r;
  logic signed [SW-1:0]    sum_re_s, sum_im_s;
  logic [WIDTH-1:0]        res_re_s, res_im_s;
  logic                    ovf_re_s, ovf_im_s;

  logic [2*WIDTH-1:0]      out_r;
  logic [TAG_W-1:0]        out_tag_r;
  logic                    out_ovf_r;
  logic                    ovf_sticky_r;

  // The whole pipe advances together; bubbles are kept, not collapsed.
  assign en_s     = !v3_r || out_ready;
  assign in_ready = en_s;

  always_comb begin
    a_re_s     = WIDTH'(cre(cword_t'(a), WIDTH));
    a_im_s     = WIDTH'(cim(cword_t'(a), WIDTH));
    b_re_s     = WIDTH'(cre(cword_t'(b), WIDTH));
    b_im_s     = WIDTH'(cim(cword_t'(b), WIDTH));
    b_im_ext_s = {b_im_s[WIDTH-1], b_im_s};
    if (conj_b) begin
      bi_eff_s = -b_im_ext_s;
    end else begin
      bi_eff_s = b_im_ext_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r   <= 1'b0;
      ar1_r  <= '0;
      ai1_r  <= '0;
      br1_r  <= '0;
      bi1_r  <= '0;
      tag1_r <= '0;
    end else if (en_s) begin
      v1_r   <= in_valid;
      ar1_r  <= a_re_s;
      ai1_r  <= a_im_s;
      br1_r  <= b_re_s;
      bi1_r  <= bi_eff_s;
      tag1_r <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_r   <= 1'b0;
      p_rr_r <= '0;
      p_ii_r <= '0;
      p_ri_r <= '0;
      p_ir_r <= '0;
      tag2_r <= '0;
    end else if (en_s) begin
      v2_r   <= v1_r;
      p_rr_r <= PW'(ar1_r) * PW'(br1_r);
      p_ii_r <= PW'(ai1_r) * PW'(bi1_r);
      p_ri_r <= PW'(ar1_r) * PW'(bi1_r);
      p_ir_r <= PW'(ai1_r) * PW'(br1_r);
      tag2_r <= tag1_r;
    end
  end

  assign sum_re_s = SW'(p_rr_r) - SW'(p_ii_r);
  assign sum_im_s = SW'(p_ri_r) + SW'(p_ir_r);

  cmult_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_rs_re (
    .sum (sum_re_s),
    .res (res_re_s),
    .ovf (ovf_re_s)
  );

  cmult_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_rs_im (
    .sum (sum_im_s),
    .res (res_im_s),
    .ovf (ovf_im_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3_r      <= 1'b0;
      out_r     <= '0;
      out_tag_r <= '0;
      out_ovf_r <= 1'b0;
    end else if (en_s) begin
      v3_r      <= v2_r;
      out_r     <= (2*WIDTH)'(cpack(comp_t'(res_re_s), comp_t'(res_im_s), WIDTH));
      out_tag_r <= tag2_r;
      out_ovf_r <= v2_r && (ovf_re_s || ovf_im_s);
    end
  end

  // Setting beats clearing so an overflow consumed during a clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky_r <= 1'b0;
    end else if (v3_r && out_ready && out_ovf_r) begin
      ovf_sticky_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky_r <= 1'b0;
    end
  end

  assign out_valid  = v3_r;
  assign out        = out_r;
  assign out_tag    = out_tag_r;
  assign out_ovf    = out_ovf_r;
  assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed and randomized-handshake checks of complex_mult_pipe (WIDTH=16, FRAC=15);
// a second instance runs truncation + wrap on the same stimulus.
module tb_complex_mult_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, alt_in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        conj_b = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_valid, alt_out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out, alt_out;
  logic [4:0]  out_tag, alt_out_tag;
  logic        out_ovf, alt_out_ovf;
  logic        ovf_sticky, alt_ovf_sticky;
  logic        clr_ovf = 1'b0;

  int total = 0;
  int bad = 0;

  logic [37:0] exp_q[$];

  // Hand-computed table: tag order 0..4.
  logic [31:0] a_tab[5]   = '{32'h40000000, 32'h40004000, 32'h40004000, 32'h80000000, 32'h00010000};
  logic [31:0] b_tab[5]   = '{32'h40000000, 32'h4000C000, 32'h4000C000, 32'h80000000, 32'h40000000};
  logic        c_tab[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] o_tab[5]   = '{32'h20000000, 32'h40000000, 32'h00004000, 32'h7FFF0000, 32'h00010000};
  logic        f_tab[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  complex_mult_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(op_a), .b(op_b), .conj_b(conj_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  complex_mult_pipe #(.ROUND(0), .SAT(0)) dut_alt (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(alt_in_ready),
    .a(op_a), .b(op_b), .conj_b(conj_b), .in_tag(in_tag),
    .out_valid(alt_out_valid), .out_ready(out_ready), .out(alt_out), .out_tag(alt_out_tag),
    .out_ovf(alt_out_ovf), .ovf_sticky(alt_ovf_sticky), .clr_ovf(clr_ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: round half up, shift by 15, saturate. Returns {ovf, re, im}.
  function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv, input logic cj);
    longint ar, ai, br, bi, re, im;
    logic [15:0] r16, i16;
    logic ovf;
    ar = longint'($signed(av[31:16]));
    ai = longint'($signed(av[15:0]));
    br = longint'($signed(bv[31:16]));
    bi = longint'($signed(bv[15:0]));
    if (cj) bi = -bi;
    re = ((ar * br - ai * bi) + 64'sd16384) >>> 15;
    im = ((ar * bi + ai * br) + 64'sd16384) >>> 15;
    ovf = 1'b0;
    if (re > 64'sd32767) begin r16 = 16'h7FFF; ovf = 1'b1; end
    else if (re < -64'sd32768) begin r16 = 16'h8000; ovf = 1'b1; end
    else r16 = re[15:0];
    if (im > 64'sd32767) begin i16 = 16'h7FFF; ovf = 1'b1; end
    else if (im < -64'sd32768) begin i16 = 16'h8000; ovf = 1'b1; end
    else i16 = im[15:0];
    return {ovf, r16, i16};
  endfunction

  task automatic send_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic cj, input logic [31:0] exp_out, input logic exp_ovf,
                          input logic [31:0] exp_alt, input logic clr_at_out);
    op_a = av; op_b = bv; conj_b = cj; in_tag = 5'd9; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_val({nm, "_lat2"}, out_valid, 1'b0);
    step();
    check_val({nm, "_valid"}, out_valid, 1'b1);
    check_val({nm, "_out"}, out, exp_out);
    check_val({nm, "_ovf"}, out_ovf, exp_ovf);
    check_val({nm, "_tag"}, out_tag, 5'd9);
    check_val({nm, "_alt_out"}, alt_out, exp_alt);
    clr_ovf = clr_at_out;
    step();
    clr_ovf = 1'b0;
  endtask

  task automatic stream(input int n, input int start, input bit use_tab, input bit rnd);
    int sent;
    int cyc;
    int idx;
    logic [37:0] e;
    logic [32:0] m;
    sent = start;
    cyc = 0;
    while ((sent < n || exp_q.size() != 0) && cyc < 20000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      in_tag    = 5'(sent);
      if (use_tab) begin
        idx = (sent < n) ? sent : 0;
        op_a = a_tab[idx]; op_b = b_tab[idx]; conj_b = c_tab[idx];
      end else if ($urandom_range(0, 7) == 0) begin
        op_a = 32'h80008000; op_b = 32'h80008000; conj_b = 1'($urandom_range(0, 1));
      end else begin
        op_a = $urandom; op_b = $urandom; conj_b = 1'($urandom_range(0, 1));
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("stream_extra", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_val("stream_out", {out_tag, out_ovf, out}, e);
        end
      end
      if (in_valid && in_ready) begin
        if (use_tab) begin
          exp_q.push_back({5'(sent), f_tab[sent], o_tab[sent]});
        end else begin
          m = model(op_a, op_b, conj_b);
          exp_q.push_back({5'(sent), m});
        end
        sent++;
      end
      step();
      cyc++;
    end
    check_val("stream_drain", exp_q.size(), 0);
    check_val("stream_count", sent, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out", out, 32'h0);
    check_val("rst_sticky", ovf_sticky, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_val("rst_in_ready", in_ready, 1'b1);

    send_one("half", 32'h40000000, 32'h40000000, 1'b0, 32'h20000000, 1'b0, 32'h20000000, 1'b0);
    send_one("cplx", 32'h40004000, 32'h4000C000, 1'b0, 32'h40000000, 1'b0, 32'h40000000, 1'b0);
    send_one("conj", 32'h40004000, 32'h4000C000, 1'b1, 32'h00004000, 1'b0, 32'h00004000, 1'b0);
    check_val("sticky_clean", ovf_sticky, 1'b0);
    send_one("ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h7FFF0000, 1'b1, 32'h80000000, 1'b0);
    check_val("ovf_alt_flag", alt_ovf_sticky, 1'b1);
    check_val("sticky_set", ovf_sticky, 1'b1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check_val("sticky_clr", ovf_sticky, 1'b0);
    send_one("ovf_clr", 32'h80000000, 32'h80000000, 1'b0, 32'h7FFF0000, 1'b1, 32'h80000000, 1'b1);
    check_val("sticky_set_wins", ovf_sticky, 1'b1);
    send_one("rnd", 32'h00010000, 32'h40000000, 1'b0, 32'h00010000, 1'b0, 32'h00000000, 1'b0);
    send_one("floor", 32'hFFFF0000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 32'hFFFF0000, 1'b0);

    // Backpressure: downstream stalled, offer five samples.
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 5);
      in_tag = 5'(acc);
      op_a = a_tab[(acc < 5) ? acc : 0];
      op_b = b_tab[(acc < 5) ? acc : 0];
      conj_b = c_tab[(acc < 5) ? acc : 0];
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({5'(acc), f_tab[acc], o_tab[acc]});
        acc++;
      end
      step();
    end
    check_val("bp_accepted", acc, 3);
    check_val("bp_in_ready", in_ready, 1'b0);
    check_val("bp_hold_valid", out_valid, 1'b1);
    check_val("bp_hold_tag", out_tag, 5'd0);
    check_val("bp_hold_out", out, 32'h20000000);
    stream(5, acc, 1'b1, 1'b0);

    stream(1000, 0, 1'b0, 1'b1);

    // Asynchronous reset with three samples in flight and the sticky flag set.
    send_one("pre_rst", 32'h80000000, 32'h80000000, 1'b0, 32'h7FFF0000, 1'b1, 32'h80000000, 1'b0);
    op_a = 32'h40000000; op_b = 32'h40000000; conj_b = 1'b0; in_tag = 5'd7;
    in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    check_val("inflight_valid", out_valid, 1'b1);
    check_val("inflight_sticky", ovf_sticky, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_valid", out_valid, 1'b0);
    check_val("async_rst_sticky", ovf_sticky, 1'b0);
    check_val("async_rst_tag", out_tag, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_val("post_rst_in_ready", in_ready, 1'b1);
    step();
    step();
    check_val("post_rst_no_stale", out_valid, 1'b0);
    send_one("post_rst", 32'h40004000, 32'h4000C000, 1'b1, 32'h00004000, 1'b0, 32'h00004000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_mult_pipe.md
# complex_mult_pipe

Pipelined, parametrised complex multiplier with valid/ready flow control, selectable rounding and saturation, per-sample conjugation of the second operand, and overflow reporting. It sits in the FFT butterfly datapath between the twiddle ROM and the add/subtract stage. It replaces the combinational multiplier there. It keeps full-precision products until one final round/saturate step, which makes it safe for any operand pair, including both operands at maximum negative magnitude.

## Interface
- `WIDTH`, default 16: bits per real/imag component, two's complement.
- `FRAC`, default `WIDTH-1`: fractional bits of operands and result; must satisfy 1 ≤ FRAC ≤ 2·WIDTH-2.
- `ROUND`, default 1: 1 = round half up; 0 = truncate (floor).
- `SAT`, default 1: 1 = saturate on overflow; 0 = wrap.
- `TAG_W`, default 5: width of the sideband tag carried alongside each sample (e.g. a bin index).
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input sample present.
- `in_ready`, out, 1: the block accepts a sample this cycle.
- `a`, in, 2·WIDTH: packed {re, im}, with re in the upper half.
- `b`, in, 2·WIDTH: packed {re, im}.
- `conj_b`, in, 1: per-sample; when 1, compute a·conj(b).
- `in_tag`, in, TAG_W: sideband value, passed through unchanged.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `out`, out, 2·WIDTH: packed {re, im} result.
- `out_tag`, out, TAG_W: tag belonging to `out`.
- `out_ovf`, out, 1: this result overflowed in re or im.
- `ovf_sticky`, out, 1: OR of all `out_ovf` flags since the last clear.
- `clr_ovf`, in, 1: synchronous clear of `ovf_sticky`.

## Operation
- Three register stages, S1 → S2 → S3. Each stage has a valid bit v1/v2/v3.
- Global advance: en = !v3 | out_ready. Also, in_ready = en.
- A sample is accepted when in_valid && en. When en is low, all stages hold their contents.
- S1 registers the operands, conj_b and the tag. It forms b_im_eff as a (WIDTH+1)-bit value: b_im_eff = −b_im if conj_b is 1, otherwise b_im. Because the value is WIDTH+1 bits, −(−2^(WIDTH−1)) is exact.
- S2 registers four full-precision products: ar·br, ai·bi_eff, ar·bi_eff, ai·br. Each is 2·WIDTH+1 bits. There is no per-product truncation.
- S3 computes the two sums in 2·WIDTH+2 bits:
  - re = ar·br − ai·bi_eff
  - im = ar·bi_eff + ai·br
- S3 then processes each sum:
  - If ROUND is 1, add 2^(FRAC−1) to the sum.
  - Arithmetic-shift right by FRAC.
  - A component overflows when the shifted value lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - If SAT is 1, an overflowed component clamps to the nearest bound. If SAT is 0, only the low WIDTH bits are kept.
  - out_ovf = ovf_re | ovf_im. The flag is reported in both SAT modes.
- `ovf_sticky` is set when out_valid && out_ready && out_ovf, and cleared by clr_ovf. If set and clear happen in the same cycle, set wins.
- Ordering is strict FIFO. A sample is never dropped or duplicated.

## Timing
- Latency is 3 cycles from acceptance to out_valid, when there is no stall. Sustained throughput is 1 sample/cycle while out_ready is 1.
- Combinational paths:
  - in_ready depends on out_ready.
  - There is no combinational path from in_valid, a or b to any output.
- While out_ready is 0, the block accepts at most 3 samples before in_ready falls. Bubbles inside the pipeline are not collapsed.
- out_valid, out, out_tag and out_ovf remain stable while out_valid && !out_ready.
- Reset (asynchronous assert, including mid-stream):
  - v1, v2, v3, ovf_sticky, out, out_tag and out_ovf all go to 0. Hence out_valid = 0.
  - in_ready = 1 in the first cycle after deassertion.
  - In-flight samples are discarded.
- Reset deassertion is synchronised externally. The block assumes a clean release.

## Structure
- Package `cmult_pkg` holds:
  - constants `RND_TRUNC` = 0 and `RND_HALF_UP` = 1;
  - functions `cpack(re, im)`, `cre(x)` and `cim(x)`, parametrised via WIDTH.
- One sub-module, `cmult_round_sat`, is instantiated twice in S3 (once for re, once for im).
  - Input: the (2·WIDTH+2)-bit sum.
  - Outputs: the WIDTH-bit result and the overflow flag.
  - Parameters: WIDTH, FRAC, ROUND, SAT.
- The product and sum widths are local parameters of the top module.

## Test plan
All cases use WIDTH=16, FRAC=15 and out_ready=1 unless stated otherwise.
- a=(0x4000,0), b=(0x4000,0) → out=(0x2000,0) 3 cycles after acceptance, out_ovf=0.
- a=(0x4000,0x4000), b=(0x4000,0xC000), conj_b=0 → (0x4000,0x0000). Same operands with conj_b=1 → (0x0000,0x4000).
- a=(0x8000,0), b=(0x8000,0):
  - SAT=1 → re=0x7FFF, out_ovf=1, ovf_sticky=1.
  - SAT=0 → re=0x8000, out_ovf=1.
  - clr_ovf pulse afterwards → ovf_sticky=0.
  - clr_ovf asserted in the same cycle as a new overflow → ovf_sticky stays 1.
- a=(0x0001,0), b=(0x4000,0) → ROUND=1 gives re=0x0001; ROUND=0 gives re=0x0000.
- Backpressure:
  - Hold out_ready=0 and offer 5 samples with tags 0..4 → exactly 3 are accepted, then in_ready=0.
  - Release out_ready → all 5 emerge in tag order with the correct values and no loss.
  - Random out_ready toggling over 1000 samples matches the reference model.
- Assert reset_n=0 with 3 samples in flight → out_valid=0 immediately (asynchronously) and ovf_sticky=0. After release, the next sample emerges with latency 3 and no stale data.
